acc_unit: RTL and testbench
===========================

// Module: acc_unit
// PURPOSE
//   Registered, parametrised accumulator for the datapath, the successor to the combinational accumulator select mux.
//   - Selects one of NSRC source buses (immediate, regfile, memory, ALU, ...).
//   - Loads, adds or subtracts the selected source into a WIDTH-bit register and keeps Z/N/C flags.
//   - Saves and restores the accumulator on a STACK_DEPTH-entry LIFO (call/interrupt save).
//   - Sits between the source buses and the ALU A-operand / memory write-data paths.
// PARAMETERS
//   WIDTH        8   accumulator / source data width in bits
//   NSRC         4   number of source buses (>=2)
//   STACK_DEPTH  4   LIFO save entries (>=1)
// PORTS
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   src_data   in   NSRC*WIDTH     packed sources; source i = src_data[i*WIDTH +: WIDTH]
//   src_sel    in   $clog2(NSRC)   source index
//   op         in   3              operation code (see BEHAVIOUR)
//   op_valid   in   1              op is executed on this edge when high
//   acc_out    out  WIDTH          accumulator register
//   zero       out  1              acc_out == 0
//   neg        out  1              acc_out[WIDTH-1]
//   carry      out  1              carry/borrow from last ADD/SUB
//   stk_full   out  1              sp == STACK_DEPTH
//   stk_empty  out  1              sp == 0
//   stk_err    out  1              sticky: push-when-full or pop-when-empty seen
// BEHAVIOUR
//   Reset (async, rst_n low)
//     - acc_out=0, carry=0, sp=0, stk_err=0. Hence zero=1, neg=0, stk_empty=1, stk_full=0.
//     - Stack contents are don't-care.
//     - Reset mid-operation discards the op in flight; there are no partial updates.
//   Source selection
//     - src = source[src_sel].
//     - src_sel >= NSRC gives src = 0.
//   Timing
//     - All state updates on the rising clk edge when op_valid=1.
//     - Result is visible on acc_out and flags one cycle after the accepting edge. Single-cycle throughput.
//     - op_valid=0: all state holds, whatever op is.
//   Op codes
//     000 NOP    hold all state
//     001 LOAD   acc<=src; carry held
//     010 ADD    {carry,acc}<=acc+src, WIDTH+1-bit sum, modulo 2^WIDTH wrap
//     011 SUB    acc<=acc-src mod 2^WIDTH; carry<=1 iff acc<src (unsigned borrow)
//     100 PUSH   stack[sp]<=acc, sp<=sp+1; acc held
//     101 POP    acc<=stack[sp-1], sp<=sp-1; carry held
//     110 CLR    acc<=0, carry<=0, stk_err<=0; sp held
//     111 LDPUSH stack[sp]<=old acc, sp<=sp+1, acc<=src, all on the same edge
//   Flags
//     - zero and neg decode combinationally from the acc_out register, so they are always consistent with it.
//     - carry changes only on ADD, SUB and CLR.
//   Stack boundaries
//     - PUSH or LDPUSH with sp==STACK_DEPTH: stack and sp unchanged, stk_err<=1.
//       LDPUSH still performs acc<=src.
//     - POP with sp==0: acc and sp unchanged, stk_err<=1.
//     - stk_err is sticky until CLR or reset.
//     - sp range is 0..STACK_DEPTH and never wraps.
// TESTING
//   1. Reset with sources nonzero -> acc_out=0, zero=1, carry=0, stk_empty=1, stk_err=0.
//   2. LOAD src1=8'hF0, then ADD src2=8'h20 -> acc=8'h10, carry=1, zero=0, neg=0.
//   3. LOAD 8'h05, then SUB 8'h06 -> acc=8'hFF, carry=1, neg=1. Then SUB 8'hFF -> acc=0, zero=1, carry=0.
//   4. LDPUSH 8'hA1, 8'hA2, 8'hA3, 8'hA4 from acc=0:
//      -> stk_full=1 after the 4th.
//      -> a 5th LDPUSH of 8'hA5 gives acc=8'hA5, stk_err=1, sp=4.
//      -> 4 POPs return acc=8'hA3, 8'hA2, 8'hA1, 8'h00; stk_empty=1.
//      -> a 5th POP leaves acc=8'h00 and stk_err=1 (still set).
//      -> CLR clears stk_err.
//   5. op_valid=0 with op=ADD for 3 cycles -> acc, flags and sp unchanged.
//      Assert rst_n low mid-cycle during ADD -> outputs reset immediately, no clk edge needed.
//   6. NSRC=3 build: src_sel=3, LOAD -> acc=0, zero=1.
//      Each legal src_sel loads its own bus value: 8'h11, 8'h22, 8'h33.

Source files
------------

// File: rtl/acc_unit.sv
`default_nettype none
// ============================================================================
// Module   : acc_unit
// Purpose  : Registered accumulator with a source mux, Z/N/C flags and a LIFO
//            that saves and restores the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module acc_unit #(
    parameter int WIDTH       = 8,
    parameter int NSRC        = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NSRC*WIDTH-1:0]     src_data,
    input  logic [$clog2(NSRC)-1:0]   src_sel,
    input  logic [2:0]                op,
    input  logic                      op_valid,
    output logic [WIDTH-1:0]          acc_out,
    output logic                      zero,
    output logic                      neg,
    output logic                      carry,
    output logic                      stk_full,
    output logic                      stk_empty,
    output logic                      stk_err
);

    localparam int SEL_W = $clog2(NSRC);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_PUSH   = 3'b100;
    localparam logic [2:0] OP_POP    = 3'b101;
    localparam logic [2:0] OP_CLR    = 3'b110;
    localparam logic [2:0] OP_LDPUSH = 3'b111;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [WIDTH-1:0] stack_d [STACK_DEPTH];

    logic [WIDTH-1:0] src;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic             full;
    logic             empty;

    // Out-of-range selects fall through the loop and leave src at zero.
    always_comb begin
        src = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                src = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sum      = {1'b0, acc_q} + {1'b0, src};
    assign diff     = {1'b0, acc_q} - {1'b0, src};
    assign push_idx = IDX_W'(sp_q);
    assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
    assign full     = (sp_q == SP_W'(STACK_DEPTH));
    assign empty    = (sp_q == '0);

    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        err_d   = err_q;
        sp_d    = sp_q;
        stack_d = stack_q;
        if (op_valid) begin
            case (op)
                OP_NOP: ;
                OP_LOAD: acc_d = src;
                OP_ADD:  {carry_d, acc_d} = sum;
                // diff[WIDTH] is the unsigned borrow (acc < src).
                OP_SUB:  {carry_d, acc_d} = diff;
                OP_PUSH, OP_LDPUSH: begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        stack_d[push_idx] = acc_q;
                        sp_d              = sp_q + SP_W'(1);
                    end
                    if (op == OP_LDPUSH) begin
                        acc_d = src;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        acc_d = stack_q[pop_idx];
                        sp_d  = sp_q - SP_W'(1);
                    end
                end
                OP_CLR: begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            sp_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            sp_q    <= sp_d;
        end
    end

    // Stack storage carries no reset; entries are only read below sp.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign acc_out   = acc_q;
    assign zero      = (acc_q == '0);
    assign neg       = acc_q[WIDTH-1];
    assign carry     = carry_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_unit
// Purpose  : Directed scoreboard bench for acc_unit (NSRC=4 and NSRC=3 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_unit;

    localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, ADD = 3'b010, SUB = 3'b011;
    localparam logic [2:0] PUSH = 3'b100, POP = 3'b101, CLR = 3'b110, LDPUSH = 3'b111;
    localparam logic [31:0] BG = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src_data;
    logic [1:0]  src_sel;
    logic [2:0]  op;
    logic        op_valid;
    logic [7:0]  acc_out;
    logic        zero, neg, carry, stk_full, stk_empty, stk_err;

    logic [23:0] d3_src_data;
    logic [1:0]  d3_src_sel;
    logic [2:0]  d3_op;
    logic        d3_op_valid;
    logic [7:0]  d3_acc_out;
    logic        d3_zero, d3_neg, d3_carry, d3_full, d3_empty, d3_err;

    typedef struct {
        string      tag;
        logic [7:0] acc;
        logic       c;
        logic       f;
        logic       e;
        logic       er;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    acc_unit #(.WIDTH(8), .NSRC(4), .STACK_DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_sel(src_sel),
        .op(op), .op_valid(op_valid), .acc_out(acc_out), .zero(zero), .neg(neg),
        .carry(carry), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    acc_unit #(.WIDTH(8), .NSRC(3), .STACK_DEPTH(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .src_data(d3_src_data), .src_sel(d3_src_sel),
        .op(d3_op), .op_valid(d3_op_valid), .acc_out(d3_acc_out), .zero(d3_zero),
        .neg(d3_neg), .carry(d3_carry), .stk_full(d3_full), .stk_empty(d3_empty),
        .stk_err(d3_err)
    );

    task automatic chk(input string tag, input string fld, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic expect_push(input string tag, input logic [7:0] ea, input logic ec,
                               input logic ef, input logic ee, input logic eer);
        exp_t x;
        x.tag = tag; x.acc = ea; x.c = ec; x.f = ef; x.e = ee; x.er = eer;
        sb.push_back(x);
    endtask

    task automatic cmp_out(input logic [7:0] a, input logic z, input logic n,
                           input logic c, input logic f, input logic e, input logic er);
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            x = sb.pop_front();
            chk(x.tag, "acc",   a,  x.acc);
            chk(x.tag, "zero",  8'(z),  8'(x.acc == 8'h00));
            chk(x.tag, "neg",   8'(n),  8'(x.acc[7]));
            chk(x.tag, "carry", 8'(c),  8'(x.c));
            chk(x.tag, "full",  8'(f),  8'(x.f));
            chk(x.tag, "empty", 8'(e),  8'(x.e));
            chk(x.tag, "err",   8'(er), 8'(x.er));
        end
    endtask

    // Called at a negedge: drive, let one rising edge accept, check at next negedge.
    task automatic step(input string tag, input logic [2:0] o, input logic [1:0] sel,
                        input logic [7:0] val, input logic v, input logic [7:0] ea,
                        input logic ec, input logic ef, input logic ee, input logic eer);
        src_data = BG;
        src_data[sel*8 +: 8] = val;
        src_sel  = sel;
        op       = o;
        op_valid = v;
        expect_push(tag, ea, ec, ef, ee, eer);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        cmp_out(acc_out, zero, neg, carry, stk_full, stk_empty, stk_err);
    endtask

    task automatic step3(input string tag, input logic [1:0] sel, input logic [7:0] ea);
        d3_src_sel  = sel;
        d3_op       = LOAD;
        d3_op_valid = 1'b1;
        expect_push(tag, ea, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        d3_op_valid = 1'b0;
        cmp_out(d3_acc_out, d3_zero, d3_neg, d3_carry, d3_full, d3_empty, d3_err);
    endtask

    initial begin
        rst_n       = 1'b0;
        src_data    = BG;
        src_sel     = 2'd1;
        op          = ADD;
        op_valid    = 1'b1;
        d3_src_data = {8'h33, 8'h22, 8'h11};
        d3_src_sel  = 2'd0;
        d3_op       = LOAD;
        d3_op_valid = 1'b0;

        // Reset with nonzero sources and a valid op pending
        repeat (2) @(negedge clk);
        expect_push("reset", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        cmp_out(acc_out, zero, neg, carry, stk_full, stk_empty, stk_err);
        op_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        step("load_f0", LOAD, 2'd1, 8'hF0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("add_20",  ADD,  2'd2, 8'h20, 1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0);
        step("load_05", LOAD, 2'd3, 8'h05, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0);
        step("sub_06",  SUB,  2'd0, 8'h06, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        step("sub_ff",  SUB,  2'd1, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        step("ldpush1", LDPUSH, 2'd1, 8'hA1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ldpush2", LDPUSH, 2'd2, 8'hA2, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ldpush3", LDPUSH, 2'd3, 8'hA3, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ldpush4", LDPUSH, 2'd0, 8'hA4, 1'b1, 8'hA4, 1'b0, 1'b1, 1'b0, 1'b0);
        step("ldpush5", LDPUSH, 2'd1, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        step("pop1",    POP,    2'd0, 8'h00, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1);
        step("pop2",    POP,    2'd0, 8'h00, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1);
        step("pop3",    POP,    2'd0, 8'h00, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("pop4",    POP,    2'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        step("pop5",    POP,    2'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        step("clr",     CLR,    2'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        step("load_7f", LOAD, 2'd2, 8'h7F, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
        step("add_01",  ADD,  2'd2, 8'h01, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        step("push",    PUSH, 2'd2, 8'h01, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        step("hold1",   ADD,  2'd2, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        step("hold2",   ADD,  2'd2, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        step("hold3",   ADD,  2'd2, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        step("nop",     NOP,  2'd2, 8'h01, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        step("pop_ret", POP,  2'd0, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        step("add_ff",  ADD,  2'd3, 8'hFF, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0);
        step("ldpushc", LDPUSH, 2'd1, 8'h33, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);

        // Mid-cycle async reset while an ADD is pending
        src_data = BG;
        src_sel  = 2'd2;
        op       = ADD;
        op_valid = 1'b1;
        expect_push("async_rst", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        cmp_out(acc_out, zero, neg, carry, stk_full, stk_empty, stk_err);
        @(negedge clk);
        op_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        step("post_rst", NOP, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // NSRC=3 build: out-of-range select yields zero
        step3("n3_sel0", 2'd0, 8'h11);
        step3("n3_sel3", 2'd3, 8'h00);
        step3("n3_sel1", 2'd1, 8'h22);
        step3("n3_sel2", 2'd2, 8'h33);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
